// File: rtl/csirx_packetparse.sv
// CSI-2 packet parser for a 2-lane receiver.
// Decodes the packet header from aligned 16-bit words and reports short
// packets on a sideband strobe. For long packets it strips the header and
// CRC and streams the payload on an AXI-Stream style output with one
// holding register. tlast marks the end of line; tuser marks the first
// beat after a Frame Start.
module csirx_packetparse #(
  parameter int N_DATA_LANES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        burst_active,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        m_axis_tvalid,
  output logic [15:0] m_axis_tdata,
  output logic [1:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        sp_valid,
  output logic [5:0]  sp_dt,
  output logic [15:0] sp_data,
  output logic [5:0]  lp_dt,
  output logic        err_truncated,
  output logic        err_overflow
);

  // Only the 2-lane word format is implemented.
  if (N_DATA_LANES != 2) begin : g_lane_check
    $error("csirx_packetparse: only N_DATA_LANES = 2 is supported");
  end

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR1    = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CRC     = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [5:0]  dt_q, dt_d;
  logic [7:0]  wc_lo_q, wc_lo_d;
  logic [15:0] remaining_q, remaining_d;
  logic        sof_q, sof_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [1:0]  out_keep_q, out_keep_d;
  logic        out_last_q, out_last_d;
  logic        out_user_q, out_user_d;
  logic        sp_valid_q, sp_valid_d;
  logic [5:0]  sp_dt_q, sp_dt_d;
  logic [15:0] sp_data_q, sp_data_d;
  logic [5:0]  lp_dt_q, lp_dt_d;
  logic        trunc_q, trunc_d;
  logic        ovf_q, ovf_d;

  logic [15:0] wc_s;
  logic        pay_word_s;
  logic [1:0]  pay_keep_s;
  logic        pay_last_s;

  assign wc_s = {word_in[7:0], wc_lo_q};

  // Header parsing, payload counting and output-register next state.
  always_comb begin
    state_d     = state_q;
    dt_d        = dt_q;
    wc_lo_d     = wc_lo_q;
    remaining_d = remaining_q;
    sof_d       = sof_q;
    sp_valid_d  = 1'b0;
    sp_dt_d     = sp_dt_q;
    sp_data_d   = sp_data_q;
    lp_dt_d     = lp_dt_q;
    trunc_d     = 1'b0;
    ovf_d       = ovf_q;
    pay_word_s  = 1'b0;
    pay_keep_s  = 2'b11;
    pay_last_s  = 1'b0;

    if (!burst_active) begin
      state_d = ST_IDLE;
      if ((state_q == ST_HDR1) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC)) begin
        trunc_d = 1'b1;
      end else begin
        trunc_d = 1'b0;
      end
    end else if (word_valid) begin
      case (state_q)
        ST_IDLE: begin
          dt_d    = word_in[5:0];
          wc_lo_d = word_in[15:8];
          state_d = ST_HDR1;
        end
        ST_HDR1: begin
          if (dt_q < 6'h10) begin
            sp_valid_d = 1'b1;
            sp_dt_d    = dt_q;
            sp_data_d  = wc_s;
            if (dt_q == 6'h00) begin
              sof_d = 1'b1;
            end else if (dt_q == 6'h01) begin
              sof_d = 1'b0;
            end else begin
              sof_d = sof_q;
            end
            state_d = ST_DRAIN;
          end else begin
            lp_dt_d     = dt_q;
            remaining_d = wc_s;
            state_d     = (wc_s == 16'd0) ? ST_CRC : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pay_word_s = 1'b1;
          if (remaining_q >= 16'd2) begin
            pay_keep_s  = 2'b11;
            pay_last_s  = (remaining_q == 16'd2);
            remaining_d = remaining_q - 16'd2;
            state_d     = (remaining_q == 16'd2) ? ST_CRC : ST_PAYLOAD;
          end else begin
            // Odd word count: the high byte of this word is CRC lo, so a
            // single further word completes the CRC.
            pay_keep_s  = 2'b01;
            pay_last_s  = 1'b1;
            remaining_d = 16'd0;
            state_d     = ST_CRC;
          end
        end
        ST_CRC: begin
          // One word covers either two CRC bytes or the remaining CRC hi.
          state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Single output holding register; a word arriving while it is blocked is dropped.
  always_comb begin
    out_valid_d = out_valid_q & ~m_axis_tready;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    if (pay_word_s) begin
      if (!out_valid_q || m_axis_tready) begin
        out_valid_d = 1'b1;
        out_data_d  = word_in;
        out_keep_d  = pay_keep_s;
        out_last_d  = pay_last_s;
        out_user_d  = sof_q;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else begin
      out_valid_d = out_valid_q & ~m_axis_tready;
    end
  end

  // Overflow is sticky; tuser consumes the pending Frame Start on a real load.
  logic load_s;
  assign load_s = pay_word_s & (~out_valid_q | m_axis_tready);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dt_q        <= 6'd0;
      wc_lo_q     <= 8'd0;
      remaining_q <= 16'd0;
      sof_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
      out_keep_q  <= 2'b00;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      sp_valid_q  <= 1'b0;
      sp_dt_q     <= 6'd0;
      sp_data_q   <= 16'd0;
      lp_dt_q     <= 6'd0;
      trunc_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dt_q        <= dt_d;
      wc_lo_q     <= wc_lo_d;
      remaining_q <= remaining_d;
      sof_q       <= load_s ? 1'b0 : sof_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      sp_valid_q  <= sp_valid_d;
      sp_dt_q     <= sp_dt_d;
      sp_data_q   <= sp_data_d;
      lp_dt_q     <= lp_dt_d;
      trunc_q     <= trunc_d;
      ovf_q       <= (pay_word_s & ~load_s) ? 1'b1 : ovf_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign sp_valid      = sp_valid_q;
  assign sp_dt         = sp_dt_q;
  assign sp_data       = sp_data_q;
  assign lp_dt         = lp_dt_q;
  assign err_truncated = trunc_q;
  assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_csirx_packetparse.sv
// Randomised scoreboard bench for csirx_packetparse. Bursts are built at
// packet level (header, payload bytes, CRC, trailing bytes); a one-slot
// buffer model decides which payload words are kept or dropped under
// backpressure, and a forked monitor pops expectations on each handshake.
module tb_csirx_packetparse;

  logic        clk = 1'b0;
  logic        resetn;
  logic        burst_active;
  logic [15:0] word_in;
  logic        word_valid;
  logic        m_axis_tvalid;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic        sp_valid;
  logic [5:0]  sp_dt;
  logic [15:0] sp_data;
  logic [5:0]  lp_dt;
  logic        err_truncated;
  logic        err_overflow;

  csirx_packetparse #(.N_DATA_LANES(2)) dut (
    .clk(clk), .resetn(resetn), .burst_active(burst_active),
    .word_in(word_in), .word_valid(word_valid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .sp_valid(sp_valid), .sp_dt(sp_dt), .sp_data(sp_data), .lp_dt(lp_dt),
    .err_truncated(err_truncated), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       beat_q[$];
  logic [21:0] sp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          occ = 1'b0;
  bit          sof = 1'b0;
  bit          ovf_exp = 1'b0;
  logic [5:0]  lp_exp = 6'd0;
  int          exp_trunc = 0;
  int          obs_trunc = 0;
  int          rmode_g = 0;
  int          paycnt_g = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares on every handshake / strobe, away from the clock edge.
  task automatic monitor();
    beat_t e;
    logic [21:0] s;
    logic [15:0] m;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (beat_q.size() == 0) begin
            chk("unexpected_beat", {14'd0, m_axis_tkeep, m_axis_tdata}, 32'hFFFF_FFFF);
          end else begin
            e = beat_q.pop_front();
            m = (e.k == 2'b01) ? 16'h00FF : 16'hFFFF;
            chk("beat_data", {16'd0, m_axis_tdata & m}, {16'd0, e.d & m});
            chk("beat_ctl", {28'd0, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                {28'd0, e.k, e.l, e.u});
          end
        end
        if (sp_valid) begin
          if (sp_q.size() == 0) begin
            chk("unexpected_sp", {10'd0, sp_dt, sp_data}, 32'hFFFF_FFFF);
          end else begin
            s = sp_q.pop_front();
            chk("sp_fields", {10'd0, sp_dt, sp_data}, {10'd0, s});
          end
        end
        if (err_truncated) obs_trunc++;
      end
    end
  endtask

  // One clock of stimulus; updates the one-slot buffer model for this edge.
  task automatic step(input logic v, input logic [15:0] w, input logic pay,
                      input logic [1:0] keep, input logic last);
    logic tr;
    beat_t b;
    case (rmode_g)
      1: tr = ($urandom_range(0, 3) != 0);
      2: tr = !(v && pay && paycnt_g < 2);
      default: tr = 1'b1;
    endcase
    if (v && pay) paycnt_g++;
    word_valid = v;
    word_in = w;
    m_axis_tready = tr;
    if (occ && tr) occ = 1'b0;
    if (v && pay) begin
      if (!occ) begin
        occ = 1'b1;
        b.d = w; b.k = keep; b.l = last; b.u = sof;
        beat_q.push_back(b);
        sof = 1'b0;
      end else begin
        ovf_exp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    resetn = 1'b0;
    burst_active = 1'b0;
    word_valid = 1'b0;
    beat_q.delete();
    sp_q.delete();
    occ = 1'b0; sof = 1'b0; ovf_exp = 1'b0; lp_exp = 6'd0;
    @(posedge clk);
    #1;
    chk("reset_outs", {11'd0, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        m_axis_tuser, sp_valid, err_truncated, err_overflow}, 32'd0);
    chk("reset_fields", {4'd0, sp_dt, sp_data, lp_dt}, 32'd0);
    resetn = 1'b1;
  endtask

  // One HS burst carrying one packet, optionally cut short or reset mid-way.
  task automatic run_burst(input logic [7:0] di, input logic [15:0] wc, input int limit,
                           input int trail, input int rmode, input int rst_at);
    logic [5:0]  dt;
    bit          is_short;
    int          npay, needed, total_w, sent, k, rem;
    bit          was_reset;
    logic [15:0] words[$];
    dt = di[5:0];
    is_short = (dt < 6'h10);
    npay = is_short ? 0 : (int'(wc) + 1) / 2;
    needed = is_short ? 2 : 3 + npay;
    total_w = needed + trail;
    rmode_g = rmode;
    paycnt_g = 0;
    was_reset = 1'b0;
    sent = 0;
    words.push_back({wc[7:0], di});
    words.push_back({8'($urandom), wc[15:8]});
    for (int i = 2; i < total_w; i++) words.push_back(16'($urandom));
    burst_active = 1'b1;
    for (int i = 0; i < total_w && i < limit; i++) begin
      if (i == rst_at) begin
        reset_cycle();
        was_reset = 1'b1;
        break;
      end
      if (rmode == 1 && $urandom_range(0, 3) == 0) step(1'b0, 16'd0, 1'b0, 2'b11, 1'b0);
      if (i == 1) begin
        if (is_short) begin
          sp_q.push_back({dt, wc});
          if (dt == 6'h00) sof = 1'b1;
          if (dt == 6'h01) sof = 1'b0;
        end else begin
          lp_exp = dt;
        end
      end
      k = i - 2;
      rem = int'(wc) - 2 * k;
      step(1'b1, words[i], (!is_short && i >= 2 && i < 2 + npay),
           (rem >= 2) ? 2'b11 : 2'b01, (rem <= 2));
      sent++;
    end
    if (!was_reset && sent >= 1 && sent < needed) exp_trunc++;
    burst_active = 1'b0;
    rmode_g = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b0, 2'b11, 1'b0);
    chk("trunc_count", obs_trunc, exp_trunc);
    chk("overflow", {31'd0, err_overflow}, {31'd0, ovf_exp});
    chk("lp_dt", {26'd0, lp_dt}, {26'd0, lp_exp});
  endtask

  initial begin
    logic [7:0]  di;
    logic [15:0] wc;
    int          lim;
    resetn = 1'b0;
    burst_active = 1'b0;
    word_valid = 1'b0;
    word_in = 16'd0;
    m_axis_tready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset_cycle();

    run_burst(8'h00, 16'h0000, 99, 0, 0, -1);   // Frame Start
    run_burst(8'h2A, 16'd4, 99, 2, 0, -1);      // RAW8, tuser on first beat
    run_burst(8'h2A, 16'd3, 99, 1, 0, -1);      // odd word count
    run_burst(8'h2A, 16'd100, 12, 0, 0, -1);    // truncated after 10 payload words
    run_burst(8'h6B, 16'd6, 99, 0, 0, -1);      // normal after truncation, VC bits set
    run_burst(8'h2A, 16'd6, 99, 0, 2, -1);      // backpressure drop, tlast survives
    run_burst(8'h12, 16'd0, 99, 0, 0, -1);      // empty long packet
    run_burst(8'h01, 16'h0005, 99, 1, 0, -1);   // Frame End
    run_burst(8'h00, 16'h0007, 99, 0, 0, -1);   // Frame Start then reset mid-payload
    run_burst(8'h2A, 16'd8, 99, 0, 2, 4);
    run_burst(8'h2C, 16'd5, 99, 0, 0, -1);      // sof cleared by reset: tuser 0

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: di = {2'($urandom), 6'h00};
          1: di = {2'($urandom), 6'h01};
          default: di = {2'($urandom), 6'($urandom_range(2, 15))};
        endcase
        wc = 16'($urandom);
      end else begin
        di = {2'($urandom), 6'($urandom_range(16, 63))};
        wc = 16'($urandom_range(0, 24));
      end
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 999;
      run_burst(di, wc, lim, $urandom_range(0, 3), 1, -1);
    end

    m_axis_tready = 1'b1;
    for (int i = 0; i < 200 && beat_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("beats_left", beat_q.size(), 32'd0);
    chk("sp_left", sp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csirx_packetparse.md
Name: csirx_packetparse

Overview:
- Sits directly downstream of csirx_wordalign in the CSI-2 receiver. Consumes aligned 2-lane words and parses the CSI-2 packet header.
- Long-packet payload is stripped of header and CRC and emitted as an AXI video stream with tlast at end of line and tuser at start of frame.
- Short packets (FS/FE/LS/LE/generic) are reported on a sideband strobe.
- One packet per HS burst; trailing bytes up to end of burst are discarded.

Parameters:
- N_DATA_LANES, 2, number of lanes; only 2 is supported (word = 16 bits). Any other value is a compile-time error.

Ports:
- clk  in  1  byte clock (rxbyteclkhs)
- resetn  in  1  reset; one clock; reset is synchronous and active-low
- burst_active  in  1  high while the D-PHY HS burst is in progress (dl0_rxactivehs)
- word_in  in  16  aligned word from csirx_wordalign; [7:0] = lane0 (earlier byte), [15:8] = lane1
- word_valid  in  1  word_in valid; only asserted while burst_active; gaps allowed
- m_axis_tvalid  out  1  payload beat valid
- m_axis_tdata  out  16  payload bytes; [7:0] = earlier byte
- m_axis_tkeep  out  2  byte enables; 2'b11, or 2'b01 on the final beat of an odd word count
- m_axis_tlast  out  1  final payload beat of a long packet
- m_axis_tuser  out  1  first payload beat after a Frame Start short packet
- m_axis_tready  in  1  downstream ready
- sp_valid  out  1  one-cycle pulse: short packet received
- sp_dt  out  6  short-packet data type
- sp_data  out  16  short-packet data field (frame/line number)
- lp_dt  out  6  data type of the current/last long packet; held
- err_truncated  out  1  one-cycle pulse: burst ended before payload+CRC complete
- err_overflow  out  1  sticky; a payload beat was dropped because of backpressure; cleared only by reset

Behaviour:
- Reset: all outputs 0, state IDLE, sof_pending = 0, byte counter = 0.
- Header bytes: word0 = {WC[7:0], DI}; word1 = {ECC, WC[15:8]}.
  - DT = DI[5:0]; VC = DI[7:6] is ignored.
  - ECC is not checked.
- States:
  - IDLE: first word_valid → latch DI and WC_lo → HDR1.
  - HDR1: next word_valid → latch WC_hi.
    - If DT < 0x10 (short packet): pulse sp_valid next cycle with sp_dt = DT, sp_data = WC; set sof_pending if DT == 0x00 → DRAIN.
    - Else (long packet): lp_dt <= DT; remaining <= WC.
      - WC == 0 → CRC with crc_left = 2.
      - Otherwise → PAYLOAD.
  - PAYLOAD, per word_valid:
    - If remaining ≥ 2: emit beat with tkeep = 11; remaining -= 2.
    - If remaining == 1: emit beat with tkeep = 01 (the high byte is CRC lo); crc_left = 1.
    - The beat that brings remaining to 0 has tlast = 1.
    - On reaching 0: go to CRC, with crc_left = 2 if WC is even, 1 if WC is odd.
  - CRC: each word consumes 2 CRC bytes. crc_left of 1 or 2 is satisfied by one word → DRAIN. CRC is not checked.
  - DRAIN: ignore words until burst_active = 0 → IDLE.
- burst_active = 0 in any state:
  - Next state is IDLE.
  - If the state was HDR1, PAYLOAD or CRC, pulse err_truncated.
  - No tlast is synthesised.
  - An output beat already registered stays valid until accepted.
- Latency: payload word accepted at cycle t appears on m_axis at t+1 (single output register).
- Handshake:
  - Beat holds while tvalid && !tready.
  - If a new payload word arrives while the register is still occupied and not being accepted that cycle, the new word is dropped and err_overflow is set. Parsing and counting continue, so tlast timing is unaffected.
  - When the tlast word is the one dropped, tlast is lost.
- tuser:
  - Asserted on the first payload beat emitted after sof_pending is set; sof_pending then clears.
  - FE (DT 0x01) also clears sof_pending.
- Reset mid-packet: synchronous return to reset state; any pending beat is discarded.

Test Plan:
- FS short packet: words 0x0000 (DI = 0x00), 0x9F00 → sp_valid pulse, sp_dt = 0x00, sp_data = 0x0000; no m_axis beats.
- Long RAW8 packet: DI = 0x2A, WC = 4, words 0x042A, 0xXX00, 0x2211, 0x4433, CRC word, tready = 1 → beats 0x2211 (keep 11, tuser = 1 after the preceding FS), then 0x4433 (keep 11, tlast = 1); lp_dt = 0x2A; state DRAIN until burst_active falls.
- Odd WC = 3: payload 0x2211, 0xC133 → second beat tdata[7:0] = 0x33, keep = 01, tlast = 1; the following word is consumed as CRC hi, then DRAIN.
- Truncation: WC = 100, burst_active drops after 10 payload words → 10 beats, none with tlast; err_truncated pulses once; the next burst parses normally.
- Backpressure: tready = 0 for 2 consecutive payload words, WC = 6 → first beat held, second word dropped, err_overflow = 1 (sticky); third beat still carries tlast.
- WC = 0 long packet, then burst end → no beats, no err_truncated if the CRC word arrived before burst_active fell.
